// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - execute stage: ID/EX latch, ALU result, EX/MEM latch
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset, zeroes both latches
//   stall[5:0]     stall vector; bit2 ID held, bit3 EX held, bit4 MEM held
//   id_aluop       operation from decode
//   id_alusel      result group from decode
//   id_opv1/2      forwarded operand values
//   id_reg_waddr   destination register
//   id_we          destination write enable
//   ex_we          EX-stage write enable (forwarding), never set for x0
//   ex_reg_waddr   EX-stage destination (forwarding)
//   ex_reg_wdata   EX-stage result (forwarding)
//   mem_we         EX/MEM latched write enable
//   mem_reg_waddr  EX/MEM latched destination
//   mem_reg_wdata  EX/MEM latched result

`ifndef STAGE_EX_DEFINES
`define STAGE_EX_DEFINES
`define AluOpBus       7:0
`define AluSelBus      2:0
`define EXE_RES_NOP    3'b000
`define EXE_RES_LOGIC  3'b001
`define EXE_RES_SHIFT  3'b010
`define EXE_RES_ARITH  3'b100
`define EXE_NOP_OP     8'h00
`define EXE_ADD_OP     8'h20
`define EXE_SUB_OP     8'h22
`define EXE_SLT_OP     8'h2A
`define EXE_SLTU_OP    8'h2B
`define EXE_AND_OP     8'h24
`define EXE_OR_OP      8'h25
`define EXE_XOR_OP     8'h26
`define EXE_SLL_OP     8'h7C
`define EXE_SRL_OP     8'h02
`define EXE_SRA_OP     8'h03
`endif

module stage_ex (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [`AluOpBus]  id_aluop,
    input  logic [`AluSelBus] id_alusel,
    input  logic [31:0]       id_opv1,
    input  logic [31:0]       id_opv2,
    input  logic [4:0]        id_reg_waddr,
    input  logic              id_we,
    output logic              ex_we,
    output logic [4:0]        ex_reg_waddr,
    output logic [31:0]       ex_reg_wdata,
    output logic              mem_we,
    output logic [4:0]        mem_reg_waddr,
    output logic [31:0]       mem_reg_wdata
);

    logic [`AluOpBus]  aluop_q;
    logic [`AluSelBus] alusel_q;
    logic [31:0]       opv1_q;
    logic [31:0]       opv2_q;
    logic [4:0]        waddr_q;
    logic              we_q;

    logic [31:0]       result;
    logic [4:0]        shamt;

    // Only the ID, EX and MEM stall bits concern this stage.
    logic              unused_stall;
    assign unused_stall = ^{stall[5], stall[1:0]};

    // ID/EX latch: ID held while EX runs means EX must see a bubble,
    // otherwise the instruction in EX would execute twice.
    always_ff @(posedge clk) begin
        if (rst || (stall[2] && !stall[3])) begin
            aluop_q  <= `EXE_NOP_OP;
            alusel_q <= `EXE_RES_NOP;
            opv1_q   <= 32'd0;
            opv2_q   <= 32'd0;
            waddr_q  <= 5'd0;
            we_q     <= 1'b0;
        end else if (!stall[2]) begin
            aluop_q  <= id_aluop;
            alusel_q <= id_alusel;
            opv1_q   <= id_opv1;
            opv2_q   <= id_opv2;
            waddr_q  <= id_reg_waddr;
            we_q     <= id_we;
        end
    end

    assign shamt = opv2_q[4:0];

    always_comb begin
        result = 32'd0;
        case (alusel_q)
            `EXE_RES_ARITH: begin
                case (aluop_q)
                    `EXE_ADD_OP:  result = opv1_q + opv2_q;
                    `EXE_SUB_OP:  result = opv1_q - opv2_q;
                    `EXE_SLT_OP:  result = ($signed(opv1_q) < $signed(opv2_q)) ? 32'd1 : 32'd0;
                    `EXE_SLTU_OP: result = (opv1_q < opv2_q) ? 32'd1 : 32'd0;
                    default:      result = 32'd0;
                endcase
            end
            `EXE_RES_LOGIC: begin
                case (aluop_q)
                    `EXE_XOR_OP: result = opv1_q ^ opv2_q;
                    `EXE_OR_OP:  result = opv1_q | opv2_q;
                    `EXE_AND_OP: result = opv1_q & opv2_q;
                    default:     result = 32'd0;
                endcase
            end
            `EXE_RES_SHIFT: begin
                case (aluop_q)
                    `EXE_SLL_OP: result = opv1_q << shamt;
                    `EXE_SRL_OP: result = opv1_q >> shamt;
                    `EXE_SRA_OP: result = $unsigned($signed(opv1_q) >>> shamt);
                    default:     result = 32'd0;
                endcase
            end
            default: result = 32'd0;
        endcase
    end

    // x0 is hardwired zero, so it must never appear as a forwarding source.
    assign ex_we        = we_q && (waddr_q != 5'd0);
    assign ex_reg_waddr = waddr_q;
    assign ex_reg_wdata = result;

    // EX/MEM latch: same bubble rule one stage further down.
    always_ff @(posedge clk) begin
        if (rst || (stall[3] && !stall[4])) begin
            mem_we        <= 1'b0;
            mem_reg_waddr <= 5'd0;
            mem_reg_wdata <= 32'd0;
        end else if (!stall[3]) begin
            mem_we        <= ex_we;
            mem_reg_waddr <= ex_reg_waddr;
            mem_reg_wdata <= ex_reg_wdata;
        end
    end

endmodule
